icache: RTL and testbench

Direct-mapped, read-only instruction cache that answers the instruction fetcher's single-outstanding fetch requests. It sits between the fetcher and the memory arbiter. Hits are served from an internal line array. Misses refill a 4-word line through a word-wide memory request/ready handshake. A clear input drops any in-flight response on branch/JALR redirect.

---
 rtl/icache.sv | 180 ++++++++++++++++++
 tb/tb_icache.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with 16-byte lines and a word-wide refill port.
// A single fetch is outstanding at a time; clear cancels the pending response.
module icache #(
   parameter int unsigned INDEX_BITS = 6
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic [31:0] fetch_pc,
   input  logic        fetch_able,
   output logic [31:0] ins_out,
   output logic        ins_ready,
   input  logic        clear,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   input  logic        mem_ready
);

   localparam int unsigned NumLines = 1 << INDEX_BITS;
   localparam int unsigned TagBits  = 32 - INDEX_BITS - 4;

   typedef enum logic [2:0] {StIdle, StLookup, StRefill, StDone, StCool} state_e;

   state_e             r_state, w_state_nxt;
   logic [31:2]        r_req_pc, w_req_pc_nxt;
   logic [1:0]         r_cnt, w_cnt_nxt;
   logic [2:0][31:0]   r_buf, w_buf_nxt;
   logic               r_drop, w_drop_nxt;
   logic [31:0]        r_ins_out, w_ins_out_nxt;
   logic               r_ins_ready, w_ins_ready_nxt;
   logic               r_mem_req, w_mem_req_nxt;
   logic [31:0]        r_mem_addr, w_mem_addr_nxt;

   logic [NumLines-1:0] r_valid;
   logic [TagBits-1:0]  r_tag [NumLines];
   logic [127:0]        r_data [NumLines];

   logic [INDEX_BITS-1:0] w_idx;
   logic [TagBits-1:0]    w_tag;
   logic [1:0]            w_word;
   logic                  w_hit;
   logic [31:0]           w_hit_word;
   logic [127:0]          w_line;
   logic [31:0]           w_fill_word;
   logic                  w_line_we;
   logic                  w_unused_pc_bits;

   assign w_unused_pc_bits = ^fetch_pc[1:0];

   assign w_idx      = r_req_pc[INDEX_BITS+3:4];
   assign w_tag      = r_req_pc[31:INDEX_BITS+4];
   assign w_word     = r_req_pc[3:2];
   assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_hit_word = r_data[w_idx][{w_word, 5'b0} +: 32];

   // The last refill word is taken straight from the bus, the first three from the buffer.
   assign w_line      = {mem_data, r_buf[2], r_buf[1], r_buf[0]};
   assign w_fill_word = w_line[{w_word, 5'b0} +: 32];

   always_comb begin
      w_state_nxt     = r_state;
      w_req_pc_nxt    = r_req_pc;
      w_cnt_nxt       = r_cnt;
      w_buf_nxt       = r_buf;
      w_drop_nxt      = r_drop;
      w_ins_out_nxt   = r_ins_out;
      w_ins_ready_nxt = r_ins_ready;
      w_mem_req_nxt   = r_mem_req;
      w_mem_addr_nxt  = r_mem_addr;
      w_line_we       = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (!clear && fetch_able) begin
               w_req_pc_nxt = fetch_pc[31:2];
               w_state_nxt  = StLookup;
            end
         end
         StLookup: begin
            if (clear) begin
               w_ins_ready_nxt = 1'b0;
               w_state_nxt     = StIdle;
            end else if (w_hit) begin
               w_ins_out_nxt   = w_hit_word;
               w_ins_ready_nxt = 1'b1;
               w_state_nxt     = StDone;
            end else begin
               w_mem_req_nxt  = 1'b1;
               w_mem_addr_nxt = {r_req_pc[31:4], 4'h0};
               w_cnt_nxt      = 2'd0;
               w_state_nxt    = StRefill;
            end
         end
         StRefill: begin
            // A redirect only marks the response as dropped; the refill always completes.
            if (clear) begin
               w_drop_nxt = 1'b1;
            end
            if (mem_ready) begin
               w_cnt_nxt      = r_cnt + 2'd1;
               w_mem_addr_nxt = r_mem_addr + 32'd4;
               for (int i = 0; i < 3; i++) begin
                  if (r_cnt == i[1:0]) begin
                     w_buf_nxt[i] = mem_data;
                  end
               end
               if (r_cnt == 2'd3) begin
                  w_mem_req_nxt = 1'b0;
                  w_line_we     = 1'b1;
                  if (r_drop || clear) begin
                     w_drop_nxt  = 1'b0;
                     w_state_nxt = StIdle;
                  end else begin
                     w_ins_out_nxt   = w_fill_word;
                     w_ins_ready_nxt = 1'b1;
                     w_state_nxt     = StDone;
                  end
               end
            end
         end
         StDone: begin
            w_ins_ready_nxt = 1'b0;
            w_state_nxt     = clear ? StIdle : StCool;
         end
         StCool: begin
            w_ins_ready_nxt = 1'b0;
            w_state_nxt     = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state     <= StIdle;
         r_req_pc    <= '0;
         r_cnt       <= 2'd0;
         r_buf       <= '0;
         r_drop      <= 1'b0;
         r_ins_out   <= 32'd0;
         r_ins_ready <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= 32'd0;
      end else if (rdy_in) begin
         r_state     <= w_state_nxt;
         r_req_pc    <= w_req_pc_nxt;
         r_cnt       <= w_cnt_nxt;
         r_buf       <= w_buf_nxt;
         r_drop      <= w_drop_nxt;
         r_ins_out   <= w_ins_out_nxt;
         r_ins_ready <= w_ins_ready_nxt;
         r_mem_req   <= w_mem_req_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_valid <= '0;
      end else if (rdy_in && w_line_we) begin
         r_valid[w_idx] <= 1'b1;
      end
   end

   // Tag and data arrays need no reset; valid bits gate every use.
   always_ff @(posedge clk_in) begin
      if (rdy_in && w_line_we) begin
         r_tag[w_idx]  <= w_tag;
         r_data[w_idx] <= w_line;
      end
   end

   assign ins_out   = r_ins_out;
   assign ins_ready = r_ins_ready;
   assign mem_req   = r_mem_req;
   assign mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed fetches, a latency-3 memory model and an
// ins_ready monitor that pops expected instruction words from a queue.
module tb_icache;

   localparam int unsigned IndexBits = 6;
   localparam logic [31:0] DataKey   = 32'hA5A5_0000;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        rdy_in;
   logic [31:0] fetch_pc;
   logic        fetch_able;
   logic [31:0] ins_out;
   logic        ins_ready;
   logic        clear;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_ready;

   always #5 clk_in = ~clk_in;

   icache #(.INDEX_BITS(IndexBits)) u_dut (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .rdy_in     (rdy_in),
      .fetch_pc   (fetch_pc),
      .fetch_able (fetch_able),
      .ins_out    (ins_out),
      .ins_ready  (ins_ready),
      .clear      (clear),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_ready  (mem_ready)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] addr_log[$];
   int          pulse_cyc[$];
   int          completions = 0;
   int          cyc = 0;
   int          wait_cnt = 0;
   int          mem_lat = 3;
   logic        rdy_s;
   logic        rst_s;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: answers each word after mem_lat cycles; a transfer completes on an
   // edge where mem_ready is high and rdy_in is high.
   initial begin
      mem_ready = 1'b0;
      mem_data  = 32'd0;
      forever begin
         @(posedge clk_in);
         cyc++;
         rdy_s = rdy_in;
         rst_s = rst_n_in;
         #1;
         if (!rst_s || !rst_n_in) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
         end else if (rdy_s) begin
            if (mem_ready) begin
               mem_ready = 1'b0;
               completions++;
               wait_cnt = 0;
            end else if (mem_req) begin
               wait_cnt++;
               if (wait_cnt >= mem_lat) begin
                  mem_ready = 1'b1;
                  mem_data  = mem_addr ^ DataKey;
                  addr_log.push_back(mem_addr);
               end
            end
         end
      end
   end

   // Monitor: every ins_ready pulse must match the oldest expected word.
   initial begin
      forever begin
         @(negedge clk_in);
         if (rst_n_in && ins_ready) begin
            pulse_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_ins_ready: got ins_out=%h expected no pulse", ins_out);
            end else begin
               check("ins_out", ins_out, exp_q.pop_front());
            end
         end
      end
   end

   task automatic wait_completions(input int target, input string name);
      int n = 0;
      while (completions < target && n < 500) begin
         @(negedge clk_in);
         n++;
      end
      if (completions < target) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: timeout with %0d mem transfers, required %0d", name, completions,
                  target);
      end
   endtask

   task automatic wait_empty(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk_in);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: timeout with %0d responses pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_fetch(input logic [31:0] pc, input string name, output int start);
      start      = cyc;
      fetch_pc   = pc;
      fetch_able = 1'b1;
      wait_empty(name);
      fetch_able = 1'b0;
      repeat (4) @(negedge clk_in);
   endtask

   initial begin
      int start;
      int base;
      int pb;
      rst_n_in   = 1'b0;
      rdy_in     = 1'b1;
      fetch_pc   = 32'd0;
      fetch_able = 1'b0;
      clear      = 1'b0;
      @(negedge clk_in);
      check("rst_ins_out", ins_out, 32'd0);
      check("rst_ins_ready", {31'd0, ins_ready}, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      @(negedge clk_in);

      // Cold miss
      base = completions;
      addr_log.delete();
      exp_q.push_back(32'hA5A5_1000);
      do_fetch(32'h0000_1000, "cold_miss", start);
      check("cold_transfers", completions - base, 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("cold_mem_addr", (i < addr_log.size()) ? addr_log[i] : 32'hDEAD_BEEF,
               32'h0000_1000 + 32'(4 * i));
      end

      // Hit in the same line
      base = completions;
      exp_q.push_back(32'hA5A5_1008);
      do_fetch(32'h0000_1008, "hit", start);
      check("hit_latency", (pulse_cyc.size() > 0) ? pulse_cyc[$] - start : -1, 32'd2);
      check("hit_no_mem", completions - base, 32'd0);

      // Conflicting addresses on index 1
      base = completions;
      exp_q.push_back(32'hA5A5_1010);
      do_fetch(32'h0000_1010, "conflict_a", start);
      check("conflict_a_transfers", completions - base, 32'd4);
      base = completions;
      exp_q.push_back(32'hA5A5_1410);
      do_fetch(32'h0000_1410, "conflict_b", start);
      check("conflict_b_transfers", completions - base, 32'd4);
      base = completions;
      exp_q.push_back(32'hA5A5_1010);
      do_fetch(32'h0000_1010, "conflict_c", start);
      check("conflict_c_transfers", completions - base, 32'd4);

      // Clear after the second word: refill finishes silently, line installed
      base       = completions;
      fetch_pc   = 32'h0000_2004;
      fetch_able = 1'b1;
      wait_completions(base + 2, "clear_mid");
      clear      = 1'b1;
      fetch_able = 1'b0;
      @(negedge clk_in);
      clear = 1'b0;
      wait_completions(base + 4, "clear_end");
      repeat (6) @(negedge clk_in);
      check("clear_transfers", completions - base, 32'd4);
      base = completions;
      exp_q.push_back(32'hA5A5_2004);
      do_fetch(32'h0000_2004, "clear_refetch", start);
      check("clear_refetch_no_mem", completions - base, 32'd0);

      // fetch_able held high: one miss then hits spaced by DONE/COOL
      base = completions;
      pb   = pulse_cyc.size();
      for (int i = 0; i < 4; i++) exp_q.push_back(32'hA5A5_3000);
      fetch_pc   = 32'h0000_3000;
      fetch_able = 1'b1;
      wait_empty("hold");
      fetch_able = 1'b0;
      repeat (6) @(negedge clk_in);
      check("hold_transfers", completions - base, 32'd4);
      for (int i = 1; i < 4; i++) begin
         check("hold_spacing",
               (pulse_cyc.size() >= pb + 4) ? pulse_cyc[pb+i] - pulse_cyc[pb+i-1] : -1, 32'd4);
      end

      // Freeze mid-refill, then reset mid-refill
      base       = completions;
      fetch_pc   = 32'h0000_3020;
      fetch_able = 1'b1;
      wait_completions(base + 1, "freeze_start");
      rdy_in = 1'b0;
      repeat (5) @(negedge clk_in);
      check("freeze_mem_addr", mem_addr, 32'h0000_3024);
      check("freeze_mem_req", {31'd0, mem_req}, 32'd1);
      check("freeze_transfers", completions - base, 32'd1);
      check("freeze_ins_ready", {31'd0, ins_ready}, 32'd0);
      rdy_in = 1'b1;
      wait_completions(base + 2, "reset_mid");
      rst_n_in   = 1'b0;
      fetch_able = 1'b0;
      #1;
      check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("mid_rst_mem_addr", mem_addr, 32'd0);
      check("mid_rst_ins_out", ins_out, 32'd0);
      check("mid_rst_ins_ready", {31'd0, ins_ready}, 32'd0);
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      base = completions;
      exp_q.push_back(32'hA5A5_3020);
      do_fetch(32'h0000_3020, "post_reset", start);
      check("post_reset_transfers", completions - base, 32'd4);
      base = completions;
      exp_q.push_back(32'hA5A5_1008);
      do_fetch(32'h0000_1008, "post_reset_old", start);
      check("post_reset_old_transfers", completions - base, 32'd4);

      repeat (4) @(negedge clk_in);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
